run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/arisc_pkg.sv | 24 ++
 rtl/skid_fifo.sv | 62 ++++++
 rtl/run_sequencer.sv | 168 ++++++++++++++++
 tb/tb_run_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arisc_pkg.sv
// Shared types for the run sequencer: FSM states, host command encoding and
// the width of the run-cycle counter.
package arisc_pkg;

    localparam int unsigned RunCyclesW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoadI,
        StLoadD,
        StStart,
        StArm,
        StRun,
        StDump
    } seq_state_e;

    typedef enum logic [1:0] {
        CmdLoadI = 2'd0,
        CmdLoadD = 2'd1,
        CmdRun   = 2'd2,
        CmdDump  = 2'd3
    } seq_cmd_e;

endpackage

// File: rtl/skid_fifo.sv
// Two-entry FIFO with a registered head; a push into a full FIFO is taken
// only when the same cycle also pops.
module skid_fifo #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // When full, the slot being written is the one being popped this cycle.
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Host-side sequencer: loads IRAM/DRAM from a stream, starts and times a CPU
// run, and dumps DRAM back out through a small read-ahead FIFO.
module run_sequencer
    import arisc_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned IW        = 16,
    parameter int unsigned RAM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [IW-1:0]         s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [W-1:0]          m_data,
    output logic                  start,
    input  logic                  idle,
    input  logic [W-1:0]          cpu_iram_addr,
    input  logic [W-1:0]          cpu_dram_addr,
    input  logic [W-1:0]          cpu_dram_din,
    input  logic                  cpu_dram_write,
    output logic                  iram_write,
    output logic [W-1:0]          iram_addr,
    output logic [IW-1:0]         iram_din,
    output logic                  dram_write,
    output logic [W-1:0]          dram_addr,
    output logic [W-1:0]          dram_din,
    input  logic [W-1:0]          dram_dout,
    output logic                  busy,
    output logic [RunCyclesW-1:0] run_cycles
);

    localparam logic [W-1:0] LastAddr = W'(RAM_DEPTH - 1);

    seq_state_e            state_q, state_d;
    logic [W:0]            ptr_q, ptr_d;
    logic [RunCyclesW-1:0] run_cycles_q, run_cycles_d, run_cycles_inc;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_last_q, rd_last_d;
    logic                  rd_issue;
    logic                  at_last;
    logic                  cpu_owns;
    logic [2:0]            committed;

    logic [W:0]            fifo_data;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic                  fifo_pop;

    assign at_last        = (ptr_q[W-1:0] == LastAddr);
    assign fifo_pop       = fifo_valid && m_ready;
    assign run_cycles_inc = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 1'b1;
    // Entries that will still occupy the FIFO after this cycle's pop.
    assign committed      = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        run_cycles_d = run_cycles_q;
        rd_issue     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    ptr_d = '0;
                    unique case (seq_cmd_e'(cmd))
                        CmdLoadI: state_d = StLoadI;
                        CmdLoadD: state_d = StLoadD;
                        CmdRun: begin
                            state_d      = StStart;
                            run_cycles_d = '0;
                        end
                        CmdDump:  state_d = StDump;
                    endcase
                end
            end
            StLoadI, StLoadD: begin
                if (s_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (s_last || at_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StStart: state_d = StArm;
            StArm: begin
                run_cycles_d = run_cycles_inc;
                if (!idle) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                run_cycles_d = run_cycles_inc;
                if (idle) begin
                    state_d = StIdle;
                end
            end
            StDump: begin
                rd_issue = !ptr_q[W] && (committed < 3'd2);
                if (rd_issue) begin
                    ptr_d = ptr_q + 1'b1;
                end
                if (fifo_pop && fifo_data[W]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        rd_pend_d = rd_issue;
        rd_last_d = rd_issue && at_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            run_cycles_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            run_cycles_q <= run_cycles_d;
            rd_pend_q    <= rd_pend_d;
            rd_last_q    <= rd_last_d;
        end
    end

    always_comb begin
        cpu_owns   = (state_q == StStart) || (state_q == StArm) || (state_q == StRun);
        cmd_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        s_ready    = (state_q == StLoadI) || (state_q == StLoadD);
        start      = (state_q == StStart);
        iram_write = (state_q == StLoadI) && s_valid;
        iram_addr  = cpu_owns ? cpu_iram_addr : ptr_q[W-1:0];
        iram_din   = s_data;
        dram_write = cpu_owns ? cpu_dram_write : ((state_q == StLoadD) && s_valid);
        dram_addr  = cpu_owns ? cpu_dram_addr : ptr_q[W-1:0];
        dram_din   = cpu_owns ? cpu_dram_din : s_data[W-1:0];
    end

    // Read data returns one cycle after issue; tag it with its last-word flag.
    skid_fifo #(
        .Width(W + 1)
    ) u_dump_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (rd_pend_q),
        .data_i ({rd_last_q, dram_dout}),
        .pop_i  (fifo_pop),
        .data_o (fifo_data),
        .valid_o(fifo_valid),
        .count_o(fifo_count)
    );

    assign m_valid    = fifo_valid;
    assign m_data     = fifo_data[W-1:0];
    assign m_last     = fifo_valid && fifo_data[W];
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with behavioural IRAM/DRAM models and a
// stub CPU driven from the stimulus sequence.
module tb_run_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [7:0]  m_data;
    logic        start;
    logic        idle;
    logic [7:0]  cpu_iram_addr;
    logic [7:0]  cpu_dram_addr;
    logic [7:0]  cpu_dram_din;
    logic        cpu_dram_write;
    logic        iram_write;
    logic [7:0]  iram_addr;
    logic [15:0] iram_din;
    logic        dram_write;
    logic [7:0]  dram_addr;
    logic [7:0]  dram_din;
    logic [7:0]  dram_dout;
    logic        busy;
    logic [31:0] run_cycles;

    int tests;
    int fails;

    logic [15:0] iram_mem [256];
    logic [7:0]  dram_mem [256];

    run_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_last        (s_last),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .m_data        (m_data),
        .start         (start),
        .idle          (idle),
        .cpu_iram_addr (cpu_iram_addr),
        .cpu_dram_addr (cpu_dram_addr),
        .cpu_dram_din  (cpu_dram_din),
        .cpu_dram_write(cpu_dram_write),
        .iram_write    (iram_write),
        .iram_addr     (iram_addr),
        .iram_din      (iram_din),
        .dram_write    (dram_write),
        .dram_addr     (dram_addr),
        .dram_din      (dram_din),
        .dram_dout     (dram_dout),
        .busy          (busy),
        .run_cycles    (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            iram_mem[i] <= 16'hFFFF;
            dram_mem[i] <= 8'h00;
        end
        dram_dout <= 8'h00;
    end

    always @(posedge clk) begin
        if (iram_write) iram_mem[iram_addr] <= iram_din;
        if (dram_write) dram_mem[dram_addr] <= dram_din;
        dram_dout <= dram_mem[dram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_iram_write"}, iram_write, 0);
        chk({tag, "_dram_write"}, dram_write, 0);
        chk({tag, "_run_cycles"}, run_cycles, 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        #1;
        chk("cmd_ready_at_issue", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    int   acc;
    int   exp_word;
    logic done;
    logic [15:0] li_words [3];

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'd0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 16'h0000;
        m_ready = 1'b0;
        idle = 1'b1;
        cpu_iram_addr = 8'h00;
        cpu_dram_addr = 8'h00;
        cpu_dram_din = 8'h00;
        cpu_dram_write = 1'b0;
        li_words[0] = 16'h1234;
        li_words[1] = 16'h0001;
        li_words[2] = 16'h0000;

        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // LOAD_I of three words, with a stray command that must be ignored
        send_cmd(2'd0);
        chk("loadi_s_ready", s_ready, 1);
        chk("loadi_busy", busy, 1);
        chk("loadi_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            s_valid   = 1'b1;
            s_data    = li_words[i];
            s_last    = (i == 2);
            cmd_valid = (i == 0);
            cmd       = 2'd3;
            #1;
            chk("loadi_we", iram_write, 1);
            chk("loadi_addr", iram_addr, i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        cmd_valid = 1'b0;
        chk("loadi_back_idle", cmd_ready, 1);
        chk("loadi_not_busy", busy, 0);
        chk("loadi_mem0", iram_mem[0], 16'h1234);
        chk("loadi_mem1", iram_mem[1], 16'h0001);
        chk("loadi_mem2", iram_mem[2], 16'h0000);
        chk("loadi_mem3_untouched", iram_mem[3], 16'hFFFF);

        // LOAD_D of 260 words without s_last: only 256 are taken, no wrap
        send_cmd(2'd1);
        acc = 0;
        for (int i = 0; i < 260; i++) begin
            s_valid = 1'b1;
            s_data  = (i < 256) ? {8'hA5, 8'(i)} : 16'h00EE;
            s_last  = 1'b0;
            #1;
            if (i == 255) chk("loadd_ready_255", s_ready, 1);
            if (i == 256) chk("loadd_ready_256", s_ready, 0);
            if (s_ready) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("loadd_accepted", acc, 256);
        chk("loadd_idle", cmd_ready, 1);
        chk("loadd_mem0", dram_mem[0], 8'h00);
        chk("loadd_mem3", dram_mem[3], 8'h03);
        chk("loadd_mem255", dram_mem[255], 8'hFF);

        // DUMP with random back-pressure
        send_cmd(2'd3);
        exp_word = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (m_valid && m_ready) begin
                chk("dump_rand_data", m_data, exp_word);
                chk("dump_rand_last", m_last, (exp_word == 255));
                if (exp_word == 255) done = 1'b1;
                exp_word++;
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("dump_rand_count", exp_word, 256);
        chk("dump_rand_idle", cmd_ready, 1);
        chk("dump_rand_empty", m_valid, 0);

        // DUMP at full rate: first word two edges after accept, then 256 in a row
        m_ready = 1'b1;
        send_cmd(2'd3);
        chk("dump_full_lat1", m_valid, 0);
        @(negedge clk);
        chk("dump_full_lat2", m_valid, 0);
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            chk("dump_full_valid", m_valid, 1);
            chk("dump_full_data", m_data, i);
            @(negedge clk);
        end
        chk("dump_full_idle", cmd_ready, 1);
        chk("dump_full_empty", m_valid, 0);
        m_ready = 1'b0;

        // RUN with stub CPU: idle low for 10 cycles, writing DRAM meanwhile
        idle = 1'b1;
        send_cmd(2'd2);
        chk("run_start_hi", start, 1);
        cpu_iram_addr = 8'h05;
        cpu_dram_addr = 8'h3C;
        #1;
        chk("run_iram_pass", iram_addr, 8'h05);
        chk("run_dram_pass", dram_addr, 8'h3C);
        @(negedge clk);
        chk("run_start_lo", start, 0);
        chk("run_busy", busy, 1);
        for (int k = 0; k < 10; k++) begin
            idle           = 1'b0;
            cpu_dram_write = 1'b1;
            cpu_dram_addr  = 8'(8'h40 + k);
            cpu_dram_din   = 8'(8'hC0 + k);
            #1;
            chk("run_dram_we", dram_write, 1);
            chk("run_dram_din", dram_din, 8'(8'hC0 + k));
            @(negedge clk);
        end
        idle = 1'b1;
        cpu_dram_write = 1'b0;
        @(negedge clk);
        chk("run_idle", cmd_ready, 1);
        chk("run_cycles", run_cycles, 11);
        chk("run_wr_first", dram_mem[8'h40], 8'hC0);
        chk("run_wr_last", dram_mem[8'h49], 8'hC9);

        // Reset in the middle of RUN
        send_cmd(2'd2);
        @(negedge clk);
        idle = 1'b0;
        cpu_dram_write = 1'b1;
        cpu_dram_addr = 8'h20;
        cpu_dram_din = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrun_rst");
        rst = 1'b0;
        idle = 1'b1;
        cpu_dram_write = 1'b0;
        @(negedge clk);

        // Reset in the middle of DUMP, after the FIFO has filled and drained a bit
        m_ready = 1'b0;
        send_cmd(2'd3);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("middump_full_valid", m_valid, 1);
        chk("middump_full_data", m_data, 8'h00);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("middump_pop_data", m_data, i);
            @(negedge clk);
        end
        rst = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        chk_reset_vals("middump_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("middump_stays_empty", m_valid, 0);
        chk("middump_stays_idle", cmd_ready, 1);

        // A fresh LOAD_I after reset starts again at address 0
        send_cmd(2'd0);
        s_valid = 1'b1;
        s_data = 16'hBEEF;
        s_last = 1'b0;
        #1;
        chk("reload_addr0", iram_addr, 8'h00);
        @(negedge clk);
        s_data = 16'hCAFE;
        s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("reload_idle", cmd_ready, 1);
        chk("reload_mem0", iram_mem[0], 16'hBEEF);
        chk("reload_mem1", iram_mem[1], 16'hCAFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
